// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/decode/execute sequencer owning PC and IR
// Optional reserved-opcode trap enabled by defining ILLEGAL_OP_TRAP_EN.
module cpu_sequencer #(
    parameter int PC_WIDTH          = 8,
    parameter int PROGRAM_DataWidth = 16,
    parameter int NumOpCodeBits     = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    input  logic                         step,
    input  logic                         halt_req,
    output logic [PC_WIDTH-1:0]          prog_addr,
    output logic                         prog_rd_en,
    input  logic [PROGRAM_DataWidth-1:0] prog_data,
    input  logic                         prog_valid,
    output logic [PROGRAM_DataWidth-1:0] instruction,
    input  logic                         dec_wr_en,
    input  logic                         dec_stat_wr_en,
    input  logic                         dec_cnt_wr_en,
    input  logic                         dec_add_offset,
    input  logic [PC_WIDTH-1:0]          dec_literal_adr,
    output logic                         rf_wr_en,
    output logic                         stat_wr_en,
    output logic [PC_WIDTH-1:0]          pc,
    output logic                         busy,
    output logic                         retire,
    output logic                         illegal
);

    typedef enum logic [1:0] {IDLE, FETCH, DECODE, EXECUTE} state_t;

    state_t                         state_q, state_d;
    logic [PC_WIDTH-1:0]            pc_q, pc_d;
    logic [PROGRAM_DataWidth-1:0]   ir_q, ir_d;
    logic                           single_q, single_d;
    logic [NumOpCodeBits-1:0]       opcode;
    logic                           reserved_op;
    logic                           trap_hit;
    logic                           locked;

    assign opcode      = ir_q[PROGRAM_DataWidth-1 -: NumOpCodeBits];
    assign reserved_op = (opcode >= NumOpCodeBits'(11) && opcode <= NumOpCodeBits'(15))
                       || (opcode >= NumOpCodeBits'(22));

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q, illegal_d;

    assign trap_hit  = (state_q == EXECUTE) && reserved_op;
    assign illegal_d = illegal_q | trap_hit;
    assign illegal   = illegal_q;
    assign locked    = illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end
`else
    assign trap_hit = 1'b0;
    assign illegal  = 1'b0;
    assign locked   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            single_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            single_q <= single_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        single_d   = single_q;
        prog_rd_en = 1'b0;
        rf_wr_en   = 1'b0;
        stat_wr_en = 1'b0;
        retire     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!locked && !halt_req) begin
                    if (run) begin
                        state_d  = FETCH;
                        single_d = 1'b0;
                    end else if (step) begin
                        state_d  = FETCH;
                        single_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                prog_rd_en = 1'b1;
                if (prog_valid) begin
                    ir_d    = prog_data;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = EXECUTE;
            EXECUTE: begin
                retire     = 1'b1;
                rf_wr_en   = dec_wr_en && !reserved_op;
                stat_wr_en = dec_stat_wr_en && !reserved_op;
                // Relative jumps are based on pc_q, which still addresses the branch itself here.
                if (trap_hit) begin
                    state_d = IDLE;
                end else begin
                    if (dec_cnt_wr_en && !reserved_op)
                        pc_d = dec_add_offset ? pc_q + dec_literal_adr : dec_literal_adr;
                    else
                        pc_d = pc_q + PC_WIDTH'(1);
                    state_d = (run && !halt_req && !single_q) ? FETCH : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign prog_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = ir_q;
    assign busy        = (state_q != IDLE);

endmodule
